control_unit_mc: RTL and testbench

- Parametrised multi-cycle control unit for the single-bus CPU.
- Generalises the fixed 6-bit-PC / 16-bit-instruction control path: widths become parameters, fetch and data memory get req/ack handshakes, and it adds relative branches (BZ/BNZ), register jump, HALT/resume and an ADDI immediate mode.
- Sits between instruction memory, data memory and the register-file/ALU datapath. Drives register addresses, function select and mux/write controls.

---
 rtl/cu_pkg.sv | 35 +++
 rtl/cu_decode.sv | 85 ++++++++
 rtl/control_unit_mc.sv | 119 +++++++++++
 tb/tb_control_unit_mc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcodes, state encoding, ALU codes and field offsets for the control unit
package cu_pkg;

    // Opcode map; 0000-0111 are register-register ALU ops using op[2:0] as the function.
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_BNZ  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU function-select codes the control unit produces by itself.
    localparam logic [3:0] FS_PASS_A = 4'b0000;
    localparam logic [3:0] FS_ADD    = 4'b0010;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } cu_state_t;

    // Instruction layout is [op | DR | SA | SB], each register field REG_AW wide.
    localparam int FLD_SB = 0;
    localparam int FLD_SA = 1;
    localparam int FLD_DR = 2;
    localparam int FLD_OP = 3;

    function automatic int fld_lsb(input int field, input int reg_aw);
        return field * reg_aw;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational decode of state, opcode and Z into the control bundle
module cu_decode
    import cu_pkg::*;
#(
    parameter int OP_W = 4,
    parameter int FS_W = 4
) (
    input  logic            reset,
    input  cu_state_t       state,
    input  logic [OP_W-1:0] op,
    input  logic            z,
    input  logic            dmem_ack,
    output logic            imem_req,
    output logic            dmem_req,
    output logic [FS_W-1:0] fs,
    output logic            mb,
    output logic            md,
    output logic            mw,
    output logic            rw,
    output logic            mp,
    output logic            halted
);

    // Every output defaults low; reset forces the whole bundle low without waiting for a clock.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        fs       = '0;
        mb       = 1'b0;
        md       = 1'b0;
        mw       = 1'b0;
        rw       = 1'b0;
        mp       = 1'b0;
        halted   = 1'b0;
        if (!reset) begin
            case (state)
                ST_FETCH: imem_req = 1'b1;
                ST_EXEC: begin
                    if (op[OP_W-1] == 1'b0) begin
                        fs = FS_W'(op[2:0]);
                        rw = 1'b1;
                    end else begin
                        case (op)
                            OP_W'(OP_ADDI): begin
                                fs = FS_W'(FS_ADD);
                                mb = 1'b1;
                                rw = 1'b1;
                            end
                            OP_W'(OP_LD): begin
                                md       = 1'b1;
                                dmem_req = 1'b1;
                            end
                            OP_W'(OP_ST): begin
                                mw       = 1'b1;
                                dmem_req = 1'b1;
                            end
                            OP_W'(OP_BZ): begin
                                fs = FS_W'(FS_PASS_A);
                                mp = z;
                            end
                            OP_W'(OP_BNZ): begin
                                fs = FS_W'(FS_PASS_A);
                                mp = ~z;
                            end
                            OP_W'(OP_JMP): mp = 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    if (op == OP_W'(OP_LD)) begin
                        md = 1'b1;
                        rw = dmem_ack;
                    end else begin
                        mw = 1'b1;
                    end
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_unit_mc.sv
// rtl/control_unit_mc.sv - multi-cycle control unit: PC, IR, state register and memory handshakes
module control_unit_mc
    import cu_pkg::*;
#(
    parameter int PC_W    = 6,
    parameter int REG_AW  = 4,
    parameter int OP_W    = 4,
    parameter int FS_W    = 4,
    localparam int INSTR_W = OP_W + 3 * REG_AW
) (
    input  logic               clk_main,
    input  logic               reset,
    output logic               imem_req,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] InstructIn,
    output logic [PC_W-1:0]    PC,
    output logic               dmem_req,
    input  logic               dmem_ack,
    input  logic [PC_W-1:0]    BusA,
    input  logic               Z,
    input  logic               resume,
    output logic [REG_AW-1:0]  DR,
    output logic [REG_AW-1:0]  SA,
    output logic [REG_AW-1:0]  SB,
    output logic [FS_W-1:0]    FS,
    output logic               MB,
    output logic               MD,
    output logic               MW,
    output logic               RW,
    output logic               MP,
    output logic               halted
);

    localparam int SB_LSB = fld_lsb(FLD_SB, REG_AW);
    localparam int SA_LSB = fld_lsb(FLD_SA, REG_AW);
    localparam int DR_LSB = fld_lsb(FLD_DR, REG_AW);
    localparam int OP_LSB = fld_lsb(FLD_OP, REG_AW);

    cu_state_t          state;
    cu_state_t          state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [OP_W-1:0]    op;
    logic [PC_W-1:0]    br_offset;

    assign op = ir[OP_LSB +: OP_W];
    assign DR = ir[DR_LSB +: REG_AW];
    assign SA = ir[SA_LSB +: REG_AW];
    assign SB = ir[SB_LSB +: REG_AW];

    // SB doubles as a signed branch offset; widen with sign so backward branches wrap correctly.
    assign br_offset = PC_W'($signed(SB));

    cu_decode #(
        .OP_W (OP_W),
        .FS_W (FS_W)
    ) u_decode (
        .reset    (reset),
        .state    (state),
        .op       (op),
        .z        (Z),
        .dmem_ack (dmem_ack),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .fs       (FS),
        .mb       (MB),
        .md       (MD),
        .mw       (MW),
        .rw       (RW),
        .mp       (MP),
        .halted   (halted)
    );

    // State register.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fetch waits on imem_valid, memory waits on dmem_ack, halt waits on resume.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: if (imem_valid) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (op == OP_W'(OP_LD) || op == OP_W'(OP_ST)) begin
                    state_nxt = ST_MEM;
                end else if (op == OP_W'(OP_HALT)) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_MEM:  if (dmem_ack) state_nxt = ST_FETCH;
            ST_HALT: if (resume) state_nxt = ST_FETCH;
            default: state_nxt = ST_FETCH;
        endcase
    end

    // PC/IR: IR loads only on a fetch handshake; PC increments there or is redirected by a taken branch/jump.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            PC <= '0;
            ir <= '0;
        end else if (state == ST_FETCH && imem_valid) begin
            ir <= InstructIn;
            PC <= PC + PC_W'(1);
        end else if (state == ST_EXEC && MP) begin
            if (op == OP_W'(OP_JMP)) begin
                PC <= BusA;
            end else begin
                PC <= PC + br_offset;
            end
        end
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// tb/tb_control_unit_mc.sv - directed self-checking bench for control_unit_mc
module tb_control_unit_mc;

    logic        clk_main = 1'b0;
    logic        reset;
    logic        imem_req, imem_valid;
    logic [15:0] InstructIn;
    logic [5:0]  PC, BusA;
    logic        dmem_req, dmem_ack, Z, resume;
    logic [3:0]  DR, SA, SB, FS;
    logic        MB, MD, MW, RW, MP, halted;

    logic        b_reset;
    logic        b_imem_req, b_imem_valid;
    logic [18:0] b_instr;
    logic [7:0]  b_pc, b_busa;
    logic        b_dmem_req, b_dmem_ack, b_z, b_resume;
    logic [4:0]  b_dr, b_sa, b_sb;
    logic [3:0]  b_fs;
    logic        b_mb, b_md, b_mw, b_rw, b_mp, b_halted;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk_main = ~clk_main;

    control_unit_mc dut (
        .clk_main (clk_main), .reset (reset),
        .imem_req (imem_req), .imem_valid (imem_valid), .InstructIn (InstructIn),
        .PC (PC), .dmem_req (dmem_req), .dmem_ack (dmem_ack), .BusA (BusA),
        .Z (Z), .resume (resume), .DR (DR), .SA (SA), .SB (SB), .FS (FS),
        .MB (MB), .MD (MD), .MW (MW), .RW (RW), .MP (MP), .halted (halted)
    );

    control_unit_mc #(.PC_W (8), .REG_AW (5)) dut_b (
        .clk_main (clk_main), .reset (b_reset),
        .imem_req (b_imem_req), .imem_valid (b_imem_valid), .InstructIn (b_instr),
        .PC (b_pc), .dmem_req (b_dmem_req), .dmem_ack (b_dmem_ack), .BusA (b_busa),
        .Z (b_z), .resume (b_resume), .DR (b_dr), .SA (b_sa), .SB (b_sb), .FS (b_fs),
        .MB (b_mb), .MD (b_md), .MW (b_mw), .RW (b_rw), .MP (b_mp), .halted (b_halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fetch_a(input logic [15:0] ins);
        InstructIn = ins;
        imem_valid = 1'b1;
        @(negedge clk_main);
        imem_valid = 1'b0;
        #1;
    endtask

    task automatic fetch_b(input logic [18:0] ins);
        b_instr      = ins;
        b_imem_valid = 1'b1;
        @(negedge clk_main);
        b_imem_valid = 1'b0;
        #1;
    endtask

    task automatic nop_a();
        fetch_a(16'hE000);
        @(negedge clk_main);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; imem_valid = 1'b0; InstructIn = '0; dmem_ack = 1'b0;
        BusA = '0; Z = 1'b0; resume = 1'b0;
        b_reset = 1'b1; b_imem_valid = 1'b0; b_instr = '0; b_dmem_ack = 1'b0;
        b_busa = '0; b_z = 1'b0; b_resume = 1'b0;
        #1;
        check("rst_pc", 32'(PC), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_ctrl", 32'({dmem_req, MB, MD, MW, RW, MP, halted}), 32'h0);
        check("rst_regs", 32'({DR, SA, SB, FS}), 32'h0);
        @(negedge clk_main);
        reset = 1'b0; b_reset = 1'b0;
        #1;
        check("fetch_req", 32'(imem_req), 32'h1);
        check("fetch_no_rw", 32'({RW, MW}), 32'h0);

        // waiting in FETCH is unbounded and resume has no effect there
        resume = 1'b1;
        @(negedge clk_main);
        resume = 1'b0;
        #1;
        check("fetch_wait", 32'({imem_req, halted, PC}), {25'h0, 1'b1, 1'b0, 6'd0});

        // ALU op 1: DR=3 SA=2 SB=1
        fetch_a(16'h1321);
        check("alu_pc", 32'(PC), 32'd1);
        check("alu_fs_rw", 32'({FS, RW, MB, MD, MW, MP}), {23'h0, 4'h1, 1'b1, 4'h0});
        check("alu_regs", 32'({DR, SA, SB}), {20'h0, 4'd3, 4'd2, 4'd1});
        check("alu_no_req", 32'({imem_req, dmem_req}), 32'h0);
        @(negedge clk_main); #1;
        check("alu_back", 32'({imem_req, RW}), 32'h2);

        // ADDI: FS=ADD, MB=1, RW=1
        fetch_a(16'h8123);
        check("addi", 32'({FS, MB, RW}), {26'h0, 4'h2, 1'b1, 1'b1});
        @(negedge clk_main); #1;

        repeat (3) nop_a();
        check("nop_pc", 32'(PC), 32'd5);

        // BZ taken: 6 + (-2) = 4
        Z = 1'b1;
        fetch_a(16'hB02E);
        check("bz_mp", 32'({MP, FS, RW}), {26'h0, 1'b1, 4'h0, 1'b0});
        @(negedge clk_main); #1;
        check("bz_taken_pc", 32'(PC), 32'd4);
        nop_a();
        Z = 1'b0;
        fetch_a(16'hB02E);
        check("bz_nt_mp", 32'(MP), 32'h0);
        @(negedge clk_main); #1;
        check("bz_nt_pc", 32'(PC), 32'd6);

        // BNZ taken with Z=0: 7 + 1 = 8
        fetch_a(16'hC001);
        check("bnz_mp", 32'(MP), 32'h1);
        @(negedge clk_main); #1;
        check("bnz_pc", 32'(PC), 32'd8);

        // LD: EXEC plus three MEM cycles, ack in the last one
        fetch_a(16'h9412);
        check("ld_exec", 32'({dmem_req, MD, RW, MW}), 32'hC);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_main); #1;
            check("ld_wait", 32'({dmem_req, MD, RW, MW}), 32'hC);
        end
        @(negedge clk_main);
        dmem_ack = 1'b1;
        #1;
        check("ld_ack", 32'({dmem_req, MD, RW, MW}), 32'hE);
        @(negedge clk_main);
        dmem_ack = 1'b0;
        #1;
        check("ld_done", 32'({dmem_req, MD, RW, imem_req}), 32'h1);
        check("ld_pc", 32'(PC), 32'd9);

        // JMP to 0x3F, then the next fetch wraps to 0
        BusA = 6'h3F;
        fetch_a(16'hD000);
        check("jmp_mp", 32'(MP), 32'h1);
        @(negedge clk_main); #1;
        check("jmp_pc", 32'(PC), 32'h3F);
        fetch_a(16'hE000);
        check("wrap_pc", 32'(PC), 32'h0);
        check("nop_ctrl", 32'({FS, MB, MD, MW, RW, MP, dmem_req}), 32'h0);
        @(negedge clk_main); #1;

        // HALT for 10 cycles, then resume
        fetch_a(16'hF000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_main); #1;
            check("halt_hold", 32'({halted, imem_req, RW, MW, PC}), {23'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1});
        end
        resume = 1'b1;
        @(negedge clk_main);
        resume = 1'b0;
        #1;
        check("resume", 32'({halted, imem_req}), 32'h1);
        fetch_a(16'hE000);
        check("resume_pc", 32'(PC), 32'd2);
        @(negedge clk_main); #1;

        // ST interrupted by reset while in MEM
        fetch_a(16'hA123);
        check("st_exec", 32'({dmem_req, MW, RW}), 32'h6);
        @(negedge clk_main); #1;
        check("st_mem", 32'({dmem_req, MW, RW}), 32'h6);
        #1;
        reset = 1'b1;
        #1;
        check("st_rst", 32'({dmem_req, MW, RW, imem_req}), 32'h0);
        check("st_rst_pc", 32'(PC), 32'h0);
        @(negedge clk_main);
        reset = 1'b0;
        #1;
        check("st_rst_fetch", 32'({imem_req, dmem_req, DR}), 32'h20);

        // Wider instance: PC_W=8, REG_AW=5
        fetch_b({4'h1, 5'd17, 5'd9, 5'd3});
        check("b_alu_pc", 32'(b_pc), 32'd1);
        check("b_alu_regs", 32'({b_dr, b_sa, b_sb, b_fs, b_rw}), {12'h0, 5'd17, 5'd9, 5'd3, 4'h1, 1'b1});
        @(negedge clk_main); #1;
        b_z = 1'b1;
        fetch_b({4'hB, 5'd0, 5'd0, 5'b11101});
        check("b_bz_mp", 32'(b_mp), 32'h1);
        @(negedge clk_main); #1;
        check("b_bz_pc", 32'(b_pc), 32'hFF);
        fetch_b({4'hE, 15'h0});
        check("b_wrap_pc", 32'(b_pc), 32'h0);
        @(negedge clk_main); #1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
